// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter arbiter state encoding and BCD limits.
package calc_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_START   = 2'd1,
      ARB_RELEASE = 2'd2,
      ARB_ACK     = 2'd3
   } arb_state_t;

   localparam logic [15:0] BIN_MAX = 16'd9999;
   localparam logic [15:0] BCD_SAT = 16'h9999;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the shared BCD converter arbiter.
interface bcd_conv_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req;
   logic [NREQ*16-1:0] bin_in;
   logic [NREQ-1:0]    ack;
   logic [15:0]        bcd_out;
   logic               ovf;
   logic               err;

   modport master (output req, bin_in, input ack, bcd_out, ovf, err);
   modport slave  (input req, bin_in, output ack, bcd_out, ovf, err);
endinterface

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Round-robin picker: first active request searching cyclically from last+1.
module rr_pick #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         grant_onehot,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    any
);
   localparam int IDW = $clog2(NREQ);

   always_comb begin
      int idx;
      idx          = 0;
      grant_onehot = '0;
      grant_id     = '0;
      any          = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!any && req[IDW'(idx)]) begin
            any                      = 1'b1;
            grant_id                 = IDW'(idx);
            grant_onehot[IDW'(idx)]  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among NREQ requesters with round-robin
// grants, overflow saturation and a converter timeout.
//
// state       | meaning
// ARB_IDLE    | waiting for any req; arbitrate and latch operand
// ARB_START   | conv_start high, waiting for conv_done or timeout
// ARB_RELEASE | start dropped, waiting for conv_done to fall
// ARB_ACK     | one-cycle ack to the granted requester
module bcd_conv_arbiter
   import calc_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   bcd_conv_arbiter_if.slave   bus,
   output logic                busy,
   output logic                conv_start,
   output logic [15:0]         conv_bin,
   input  logic                conv_done,
   input  logic [15:0]         conv_bcd
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT);

   arb_state_t       state;
   logic [IDW-1:0]   last;
   logic [NREQ-1:0]  grant_oh;
   logic [CW-1:0]    cnt;
   logic [15:0]      bcd_r;
   logic             ovf_r;
   logic             err_r;

   logic [NREQ-1:0]  pick_oh;
   logic [IDW-1:0]   pick_id;
   logic             pick_any;
   logic [15:0]      op;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req          (bus.req),
      .last         (last),
      .grant_onehot (pick_oh),
      .grant_id     (pick_id),
      .any          (pick_any)
   );

   assign op = bus.bin_in[16*pick_id +: 16];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ARB_IDLE;
         last     <= IDW'(NREQ-1);
         grant_oh <= '0;
         cnt      <= '0;
         conv_bin <= '0;
         bcd_r    <= '0;
         ovf_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_oh <= pick_oh;
                  last     <= pick_id;
                  conv_bin <= op;
                  cnt      <= '0;
                  // out-of-range operands never reach the converter
                  if (op > BIN_MAX) begin
                     bcd_r <= BCD_SAT;
                     ovf_r <= 1'b1;
                     err_r <= 1'b0;
                     state <= ARB_ACK;
                  end else begin
                     state <= ARB_START;
                  end
               end
            end
            ARB_START: begin
               if (conv_done) begin
                  bcd_r <= conv_bcd;
                  ovf_r <= 1'b0;
                  err_r <= 1'b0;
                  state <= ARB_RELEASE;
               end else if (cnt == CW'(TIMEOUT-1)) begin
                  bcd_r <= '0;
                  ovf_r <= 1'b0;
                  err_r <= 1'b1;
                  state <= ARB_ACK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ARB_RELEASE: begin
               if (!conv_done) state <= ARB_ACK;
            end
            ARB_ACK: begin
               state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign conv_start  = (state == ARB_START);
   assign busy        = (state != ARB_IDLE);
   assign bus.ack     = (state == ARB_ACK) ? grant_oh : '0;
   assign bus.bcd_out = bcd_r;
   assign bus.ovf     = ovf_r;
   assign bus.err     = err_r;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench: a cycle-level transaction model predicts grant, result and
// ack cycle; a negedge monitor compares every ack against the queue.
module tb_bcd_conv_arbiter;
   localparam int NREQ    = 3;
   localparam int TIMEOUT = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bcd_conv_arbiter_if #(.NREQ(NREQ)) bus ();

   logic        busy, conv_start, conv_done;
   logic [15:0] conv_bin, conv_bcd;

   bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .conv_start (conv_start),
      .conv_bin   (conv_bin),
      .conv_done  (conv_done),
      .conv_bcd   (conv_bcd)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total  = 0;
   int passed = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
   endtask

   function automatic logic [15:0] to_bcd(int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   // converter model: done after lat cycles of start, drops with start
   int ccnt  = 0;
   int lat   = 1;
   bit stuck = 1'b0;
   always @(posedge clk) ccnt <= conv_start ? ccnt + 1 : 0;
   assign conv_done = conv_start && !stuck && (ccnt >= lat - 1);
   assign conv_bcd  = conv_done ? to_bcd(int'(conv_bin)) : 16'hdead;

   // requester drive
   logic [NREQ-1:0] req_r = '0;
   logic [15:0]     bin_r [NREQ];
   int              auto_n [NREQ];
   logic [NREQ*16-1:0] bin_pk;
   always_comb begin
      bin_pk = '0;
      for (int i = 0; i < NREQ; i++) bin_pk[16*i +: 16] = bin_r[i];
   end
   assign bus.req    = req_r;
   assign bus.bin_in = bin_pk;

   typedef struct {
      int          id;
      logic [15:0] bcd;
      bit          ovf;
      bit          err;
      int          ackc;
   } exp_t;

   exp_t q[$];
   int   ack_log[$];
   exp_t e, ne;
   int   m_last = NREQ - 1;
   int   m_free = 0;
   int   s_lo = 1, s_hi = 0;
   int   lat_force = 0;
   int   d_id;

   // model + monitor
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         m_last = NREQ - 1;
         m_free = 0;
         s_lo   = 1;
         s_hi   = 0;
         check("rst_ack", 32'(bus.ack), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_conv_start", 32'(conv_start), 0);
      end else begin
         if (q.size() > 0 && q[0].ackc < cyc) begin
            check("ack_missing", cyc, q[0].ackc);
            void'(q.pop_front());
         end
         if (bus.ack != '0) begin
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) ack_log.push_back(i);
            if (q.size() == 0) begin
               check("ack_unexpected", 32'(bus.ack), 0);
            end else begin
               e = q.pop_front();
               check("ack_id", 32'(bus.ack), 32'(1 << e.id));
               check("ack_cycle", cyc, e.ackc);
               check("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
               check("ovf", 32'(bus.ovf), 32'(e.ovf));
               check("err", 32'(bus.err), 32'(e.err));
            end
         end
         check("busy", 32'(busy), 32'(cyc < m_free));
         check("conv_start", 32'(conv_start), 32'(cyc >= s_lo && cyc <= s_hi));
         if (cyc >= m_free && req_r != '0) begin
            d_id = -1;
            for (int k = 1; k <= NREQ; k++)
               if (d_id < 0 && req_r[(m_last + k) % NREQ]) d_id = (m_last + k) % NREQ;
            m_last = d_id;
            ne.id  = d_id;
            if (int'(bin_r[d_id]) > 9999) begin
               ne.bcd = 16'h9999; ne.ovf = 1; ne.err = 0;
               ne.ackc = cyc + 1;
               s_lo = 1; s_hi = 0;
            end else if (stuck) begin
               ne.bcd = 16'h0000; ne.ovf = 0; ne.err = 1;
               ne.ackc = cyc + TIMEOUT + 1;
               s_lo = cyc + 1; s_hi = cyc + TIMEOUT;
            end else begin
               lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 12));
               ne.bcd = to_bcd(int'(bin_r[d_id])); ne.ovf = 0; ne.err = 0;
               ne.ackc = cyc + lat + 2;
               s_lo = cyc + 1; s_hi = cyc + lat;
            end
            m_free = ne.ackc + 1;
            q.push_back(ne);
         end
      end
   end

   task automatic tick(output logic [NREQ-1:0] dropped);
      logic [NREQ-1:0] a;
      @(negedge clk);
      a = bus.ack;
      @(posedge clk);
      #1;
      dropped = req_r & a;
      req_r   = req_r & ~a;
      for (int i = 0; i < NREQ; i++)
         if (auto_n[i] > 0 && !req_r[i] && !dropped[i]) begin
            req_r[i] = 1'b1;
            auto_n[i]--;
         end
   endtask

   task automatic step();
      logic [NREQ-1:0] dm;
      tick(dm);
   endtask

   task automatic wait_quiet(int budget);
      logic [NREQ-1:0] dm;
      int n;
      bit pend;
      n = 0;
      do begin
         tick(dm);
         n++;
         pend = 1'b0;
         for (int i = 0; i < NREQ; i++) if (auto_n[i] > 0) pend = 1'b1;
      end while ((req_r != '0 || q.size() != 0 || pend) && n < budget);
      check("quiet_within_budget", 32'(n < budget), 1);
      step();
   endtask

   function automatic logic [15:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 16'd9999;
         1: return 16'd10000;
         2: return 16'd65535;
         3: return 16'd0;
         default: return 16'($urandom_range(0, 12000));
      endcase
   endfunction

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: cycle %0d reached limit 50000", cyc);
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0] dm;
      for (int i = 0; i < NREQ; i++) begin
         bin_r[i]  = '0;
         auto_n[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #2;
      check("reset_bcd_out", 32'(bus.bcd_out), 0);
      check("reset_conv_bin", 32'(conv_bin), 0);
      check("reset_ovf", 32'(bus.ovf), 0);
      check("reset_err", 32'(bus.err), 0);

      // single request, converter latency 20
      lat_force = 20;
      bin_r[0]  = 16'd1234;
      req_r[0]  = 1'b1;
      wait_quiet(200);

      // all three requesting continuously
      lat_force = 0;
      bin_r[0] = 16'd5; bin_r[1] = 16'd42; bin_r[2] = 16'd9999;
      for (int i = 0; i < NREQ; i++) auto_n[i] = 2;
      ack_log.delete();
      req_r = '1;
      wait_quiet(600);
      check("rr_ack_count", ack_log.size(), 9);
      for (int j = 1; j < ack_log.size(); j++)
         check("rr_order", ack_log[j], (ack_log[j-1] + 1) % NREQ);

      // overflow boundaries
      bin_r[1] = 16'd10000; req_r[1] = 1'b1; wait_quiet(50);
      bin_r[1] = 16'd65535; req_r[1] = 1'b1; wait_quiet(50);
      bin_r[1] = 16'd9999;  req_r[1] = 1'b1; wait_quiet(50);

      // stuck converter, then a normal request
      stuck = 1'b1;
      bin_r[0] = 16'd777; req_r[0] = 1'b1; wait_quiet(300);
      stuck = 1'b0;
      bin_r[2] = 16'd4321; req_r[2] = 1'b1; wait_quiet(100);

      // reset in the middle of START
      lat_force = 20;
      bin_r[0] = 16'd1234; req_r[0] = 1'b1;
      repeat (10) step();
      reset = 1'b1;
      #1;
      check("midrst_conv_start", 32'(conv_start), 0);
      check("midrst_busy", 32'(busy), 0);
      req_r = '0;
      repeat (2) step();
      reset = 1'b0;
      lat_force = 0;
      ack_log.delete();
      bin_r[2] = 16'd88; req_r[2] = 1'b1; wait_quiet(100);
      bin_r[0] = 16'd1; bin_r[1] = 16'd2; req_r[0] = 1'b1; req_r[1] = 1'b1;
      wait_quiet(200);
      check("after_rst_first", ack_log.size() > 0 ? ack_log[0] : -1, 2);
      check("after_rst_second", ack_log.size() > 1 ? ack_log[1] : -1, 0);
      check("after_rst_third", ack_log.size() > 2 ? ack_log[2] : -1, 1);

      // randomized traffic, including requesters giving up before grant
      repeat (500) begin
         tick(dm);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_r[i] && !dm[i] && $urandom_range(0, 3) == 0) begin
               bin_r[i] = rand_op();
               req_r[i] = 1'b1;
            end else if (req_r[i] && $urandom_range(0, 40) == 0 &&
                         !(q.size() > 0 && q[0].id == i)) begin
               req_r[i] = 1'b0;
            end
         end
      end
      wait_quiet(1000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
